issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised multi-slot instruction buffer between the fetch scheduler and the decode stage of the superscalar core. It accepts up to WIDTH {pc, instruction} entries per cycle, holds them in program order in a circular store of DEPTH entries, and presents the WIDTH oldest entries to decode, which retires 0..WIDTH of them per cycle. It generalises the fixed dual-issue execute buffer with configurable width and depth, partial dequeue, occupancy reporting and an optional empty-queue bypass.

## Interface
- DATA_W, 64: bits per entry ({pc[31:0], instr[31:0]}).
- DEPTH, 8: number of entries; power of two, at least 2*WIDTH.
- WIDTH, 2: enqueue/dequeue slots per cycle, 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all stored entries (jump or mispredict redirect).
- stall  in  1  decode hold; forces dequeue count to 0.
- enq_valid  in  WIDTH  per-slot write request; slot 0 is the oldest instruction.
- enq_data  in  WIDTH*DATA_W  slot i occupies bits [i*DATA_W +: DATA_W].
- enq_ready  out  1  high when free entries >= WIDTH.
- deq_valid  out  WIDTH  bit i high when at least i+1 entries are visible.
- deq_data  out  WIDTH*DATA_W  oldest visible entries, slot 0 oldest; invalid slots drive 0.
- deq_take  in  $clog2(WIDTH+1)  number of entries decode consumes this cycle.
- count  out  $clog2(DEPTH+1)  registered occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- State: rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count, entry store. The store is not reset.
- Enqueue count n_enq is the number of leading ones in enq_valid starting at bit 0. Bits above the first zero are ignored. n_enq is forced to 0 when enq_ready is low.
- Accepted entries are written at wr_ptr, wr_ptr+1, and so on, in slot order. wr_ptr advances by n_enq.
- Dequeue count n_deq = min(deq_take, visible entries). It is 0 when stall is high. rd_ptr advances by n_deq.
- count_next = count + n_enq - n_deq. Simultaneous enqueue and dequeue is legal in every state, including full with enq_ready low, and empty.
- flush has priority over enqueue and dequeue in the same cycle: rd_ptr, wr_ptr and count all go to 0, and entries presented that cycle are dropped.
- enq_ready depends only on registered count. It has no combinational path from deq_take, stall or flush.
- Wrap-around: each slot index is computed as (ptr + i) mod DEPTH. No entry is lost or duplicated across the boundary.

## Timing
- Reset values (cycle after rst sampled high): count 0, empty 1, full 0, enq_ready 1, deq_valid 0, deq_data 0, pointers 0.
- Latency from enqueue to deq_valid is 1 cycle in the base build. The entry is visible in the cycle after the accepting edge.
- deq_valid and deq_data are combinational from registered state, plus enq inputs when bypass is enabled.
- Dequeue takes effect at the edge. The next entries are visible in the following cycle.
- rst asserted mid-operation behaves like a flush and also overrides flush.

## Configuration
- ISSUE_QUEUE_BYPASS_EN defined: when count == 0 and flush is low, the accepted enqueue slots are presented on deq_valid/deq_data in the same cycle (0-cycle latency).
  - Entries taken by deq_take that cycle are not retained.
  - Untaken entries are written as normal.
  - count_next = n_enq - n_deq.
- ISSUE_QUEUE_BYPASS_EN undefined: no bypass. Visible entries are exactly the stored entries, and latency is 1 cycle.

## Test plan
- Reset, then idle: count=0, empty=1, enq_ready=1, deq_valid=0 for 3 cycles.
- WIDTH=2, DEPTH=8: enqueue 2 per cycle for 4 cycles with deq_take=0.
  - count reads 2, 4, 6, 8; full=1.
  - enq_ready drops once count reaches 8, i.e. free < 2.
  - A further enq_valid=2'b11 is ignored and count stays 8.
- Wrap-around: run 12 cycles with enqueue 2 and deq_take 2 each cycle, data = incrementing pc.
  - deq_data slot 0/1 pcs are strictly sequential and none is skipped.
  - count is constant at 2 (base build).
- Partial and gapped traffic: enq_valid=2'b10 -> nothing is accepted.
  - enq_valid=2'b01 -> 1 entry accepted.
  - With count=1, deq_take=2 -> only 1 is removed and count=0.
- flush with count=5, enq_valid=2'b11 and deq_take=1 in the same cycle -> next cycle count=0, empty=1, deq_valid=0. The dropped entries never appear.
- ISSUE_QUEUE_BYPASS_EN: empty queue, enq_valid=2'b11 with pc 0x100/0x104, deq_take=1.
  - The same cycle shows deq_valid=2'b11 with pc 0x100 in slot 0.
  - The next cycle shows count=1 with pc 0x104 in slot 0.

Source files
------------

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - fetch/decode handshake bundle for the issue queue.
interface issue_queue_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 2
) ();
    logic                         flush;
    logic                         stall;
    logic [WIDTH-1:0]             enq_valid;
    logic [WIDTH*DATA_W-1:0]      enq_data;
    logic                         enq_ready;
    logic [WIDTH-1:0]             deq_valid;
    logic [WIDTH*DATA_W-1:0]      deq_data;
    logic [$clog2(WIDTH+1)-1:0]   deq_take;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         empty;

    modport master (
        output flush, stall, enq_valid, enq_data, deq_take,
        input  enq_ready, deq_valid, deq_data, count, full, empty
    );

    modport slave (
        input  flush, stall, enq_valid, enq_data, deq_take,
        output enq_ready, deq_valid, deq_data, count, full, empty
    );
endinterface

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - multi-slot in-order instruction buffer between fetch and decode.
// Define ISSUE_QUEUE_BYPASS_EN to present enqueued slots on an empty queue in the same cycle.
module issue_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 2
) (
    input  logic          clk,
    input  logic          rst,
    issue_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TK_W  = $clog2(WIDTH + 1);

    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DATA_W-1:0]       mem_d [DEPTH];

    logic                    enq_ready;
    logic                    run;
    logic                    bypass;
    logic [TK_W-1:0]         n_enq;
    logic [TK_W-1:0]         n_vis;
    logic [TK_W-1:0]         n_deq;
    logic [WIDTH-1:0]        deq_valid;
    logic [WIDTH*DATA_W-1:0] deq_data;

    // Only the unbroken run of valid slots from slot 0 is accepted.
    always_comb begin
        enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH);
        n_enq     = '0;
        run       = enq_ready;
        for (int i = 0; i < WIDTH; i++) begin
            if (run && bus.enq_valid[i]) begin
                n_enq = n_enq + TK_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        bypass = 1'b0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        bypass = (count_q == '0) && !bus.flush;
`endif
        n_vis = (count_q >= CNT_W'(WIDTH)) ? TK_W'(WIDTH) : TK_W'(count_q);
        if (bypass) begin
            n_vis = n_enq;
        end
        deq_valid = '0;
        deq_data  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (TK_W'(i) < n_vis) begin
                deq_valid[i] = 1'b1;
                deq_data[i*DATA_W +: DATA_W] = bypass ? bus.enq_data[i*DATA_W +: DATA_W]
                                                      : mem_q[rd_ptr_q + PTR_W'(i)];
            end
        end
        n_deq = bus.stall ? '0 : ((bus.deq_take < n_vis) ? bus.deq_take : n_vis);
    end

    // Bypassed entries are written like any other; rd_ptr simply steps over the taken ones.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(n_deq);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
        count_d  = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
        mem_d    = mem_q;
        for (int i = 0; i < WIDTH; i++) begin
            if ((TK_W'(i) < n_enq) && !bus.flush) begin
                mem_d[wr_ptr_q + PTR_W'(i)] = bus.enq_data[i*DATA_W +: DATA_W];
            end
        end
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.enq_ready = enq_ready;
    assign bus.deq_valid = deq_valid;
    assign bus.deq_data  = deq_data;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == CNT_W'(DEPTH));
    assign bus.empty     = (count_q == '0);
endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - scoreboard bench for issue_queue (WIDTH=2, DEPTH=8).
module tb_issue_queue;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int WIDTH  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb [$];
    logic [31:0] next_pc = 32'h1000;

    function automatic logic [DATA_W-1:0] mk(input logic [31:0] pc);
        return {pc, pc ^ 32'hA5A5_0000};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check the view 1 ns later, then advance the model at the edge.
    task automatic cycle(input logic [1:0] ev, input int take, input logic fl, input logic st);
        logic [DATA_W-1:0]       ed [WIDTH];
        logic [DATA_W-1:0]       vis [$];
        logic [WIDTH-1:0]        exp_v;
        logic [WIDTH*DATA_W-1:0] exp_d;
        int cnt, n_enq, n_deq;
        ed[0] = mk(next_pc);
        ed[1] = mk(next_pc + 32'd4);
        next_pc = next_pc + 32'd8;
        bus.enq_valid = ev;
        bus.enq_data  = {ed[1], ed[0]};
        bus.deq_take  = 2'(take);
        bus.flush     = fl;
        bus.stall     = st;
        #1;
        cnt   = sb.size();
        n_enq = 0;
        if (cnt <= DEPTH - WIDTH && ev[0]) n_enq = ev[1] ? 2 : 1;
        vis.delete();
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (cnt == 0 && !fl) begin
            for (int i = 0; i < n_enq; i++) vis.push_back(ed[i]);
        end
`endif
        if (cnt != 0) begin
            for (int i = 0; i < cnt && i < WIDTH; i++) vis.push_back(sb[i]);
        end
        exp_v = '0;
        exp_d = '0;
        for (int i = 0; i < vis.size(); i++) begin
            exp_v[i] = 1'b1;
            exp_d[i*DATA_W +: DATA_W] = vis[i];
        end
        chk("count",     128'(bus.count),     128'(cnt));
        chk("empty",     128'(bus.empty),     128'(cnt == 0));
        chk("full",      128'(bus.full),      128'(cnt == DEPTH));
        chk("enq_ready", 128'(bus.enq_ready), 128'(cnt <= DEPTH - WIDTH));
        chk("deq_valid", 128'(bus.deq_valid), 128'(exp_v));
        chk("deq_data",  128'(bus.deq_data),  128'(exp_d));
        n_deq = st ? 0 : ((take < vis.size()) ? take : vis.size());
        @(posedge clk);
        if (rst || fl) begin
            sb.delete();
        end else begin
            for (int i = 0; i < n_enq; i++) sb.push_back(ed[i]);
            repeat (n_deq) void'(sb.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        bus.enq_valid = '0;
        bus.enq_data  = '0;
        bus.deq_take  = '0;
        bus.flush     = 1'b0;
        bus.stall     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (3) cycle(2'b00, 0, 1'b0, 1'b0);
        repeat (4) cycle(2'b11, 0, 1'b0, 1'b0);
        cycle(2'b11, 0, 1'b0, 1'b0);
        cycle(2'b00, 0, 1'b0, 1'b0);
        repeat (4) cycle(2'b00, 2, 1'b0, 1'b0);
        cycle(2'b00, 0, 1'b0, 1'b0);

        repeat (12) cycle(2'b11, 2, 1'b0, 1'b0);
        cycle(2'b00, 2, 1'b0, 1'b0);

        cycle(2'b10, 0, 1'b0, 1'b0);
        cycle(2'b01, 0, 1'b0, 1'b0);
        cycle(2'b00, 2, 1'b0, 1'b0);
        cycle(2'b00, 0, 1'b0, 1'b0);

        cycle(2'b11, 0, 1'b0, 1'b0);
        cycle(2'b00, 2, 1'b0, 1'b1);
        cycle(2'b00, 2, 1'b0, 1'b0);

        cycle(2'b11, 0, 1'b0, 1'b0);
        cycle(2'b11, 0, 1'b0, 1'b0);
        cycle(2'b01, 0, 1'b0, 1'b0);
        cycle(2'b11, 1, 1'b1, 1'b0);
        repeat (2) cycle(2'b11, 1, 1'b0, 1'b0);
        repeat (3) cycle(2'b00, 2, 1'b0, 1'b0);

        next_pc = 32'h100;
        cycle(2'b11, 1, 1'b0, 1'b0);
        cycle(2'b00, 0, 1'b0, 1'b0);
        cycle(2'b00, 2, 1'b0, 1'b0);

        cycle(2'b11, 0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle(2'b11, 1, 1'b1, 1'b0);
        rst = 1'b0;
        cycle(2'b00, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
